fp_result_queue: RTL and testbench

FP_RESULT_QUEUE -- requirements
Module: fp_result_queue

---
 rtl/fp_result_queue.sv | 123 ++++++++++++
 tb/tb_fp_result_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_queue.sv
// fp_result_queue: FIFO of add/sub results waiting for FP register writeback.
// Each entry carries its result, destination index and a 4-bit classification
// {nan, inf, zero, neg} that is computed once, when the entry is pushed.

// Single-precision classifier; purely combinational.
module fp_classify (
  input  logic [31:0] val_i,
  output logic [3:0]  flags_o
);
  logic [7:0]  exp;
  logic [22:0] man;

  // Split the fields; denormals (exp 0, man != 0) are not reported as zero.
  always_comb begin
    exp     = val_i[30:23];
    man     = val_i[22:0];
    flags_o = {(exp == 8'hFF) && (man != 23'd0),
               (exp == 8'hFF) && (man == 23'd0),
               (exp == 8'h00) && (man == 23'd0),
               val_i[31]};
  end
endmodule

module fp_result_queue #(
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter int DEST_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_result,
  input  logic [DEST_W-1:0]         in_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_result,
  output logic [DEST_W-1:0]         out_dest,
  output logic [3:0]                out_flags,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0]       result;
    logic [DEST_W-1:0] dest;
    logic [3:0]        flags;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          last_q;       // last popped entry, shown while empty
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      in_flags;
  logic            push, pop;

  fp_classify u_cls (
    .val_i   (in_result),
    .flags_o (in_flags)
  );

  // Handshakes depend only on registered occupancy: no out_ready or flush
  // path into in_ready, and no empty-queue bypass to the output.
  always_comb begin
    in_ready  = (count_q != FULL);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_entry  = '{result: in_result, dest: in_dest, flags: in_flags};
  end

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop && !flush) last_q <= mem[rd_ptr_q];
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= wr_entry;
  end

  // Head entry while non-empty, otherwise the last popped (or reset) values.
  always_comb begin
    count      = count_q;
    out_result = out_valid ? mem[rd_ptr_q].result : last_q.result;
    out_dest   = out_valid ? mem[rd_ptr_q].dest   : last_q.dest;
    out_flags  = out_valid ? mem[rd_ptr_q].flags  : last_q.flags;
  end
endmodule

// File: tb/tb_fp_result_queue.sv
// Directed bench for fp_result_queue (DEPTH 4, DEST_W 5).
module tb_fp_result_queue;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_result, out_result;
  logic [4:0]  in_dest, out_dest;
  logic [3:0]  out_flags;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  fp_result_queue #(.DEPTH(4), .DEST_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest),
    .out_flags(out_flags), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".count"},  32'(count), 32'd0);
    chk({tag, ".ovalid"}, 32'(out_valid), 32'd0);
    chk({tag, ".iready"}, 32'(in_ready), 32'd1);
    chk({tag, ".result"}, out_result, 32'h0);
    chk({tag, ".dest"},   32'(out_dest), 32'd0);
    chk({tag, ".flags"},  32'(out_flags), 32'd0);
  endtask

  logic [31:0] cls_val [4] = '{32'h80000000, 32'h7F800000, 32'hFFC00001, 32'h00000001};
  logic [3:0]  cls_exp [4] = '{4'b0011, 4'b0100, 4'b1001, 4'b0000};
  logic [31:0] v [6];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_dest = '0;
    #2;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single push, then pop; outputs hold the popped entry once empty.
    in_valid = 1'b1; in_result = 32'h3FC00000; in_dest = 5'd7;
    cyc();
    in_valid = 1'b0;
    chk("single.ovalid", 32'(out_valid), 32'd1);
    chk("single.result", out_result, 32'h3FC00000);
    chk("single.dest",   32'(out_dest), 32'd7);
    chk("single.flags",  32'(out_flags), 32'd0);
    chk("single.count",  32'(count), 32'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("pop.count",  32'(count), 32'd0);
    chk("pop.ovalid", 32'(out_valid), 32'd0);
    chk("pop.hold",   out_result, 32'h3FC00000);
    chk("pop.hdest",  32'(out_dest), 32'd7);

    // Classification of -0, +inf, negative NaN, denormal.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_result = cls_val[i]; in_dest = 5'(i + 1);
      cyc();
    end
    in_valid = 1'b0;
    chk("cls.count",  32'(count), 32'd4);
    chk("cls.iready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cls.flags%0d", i), 32'(out_flags), 32'(cls_exp[i]));
      chk($sformatf("cls.res%0d", i),   out_result, cls_val[i]);
      cyc();
    end
    out_ready = 1'b0;
    chk("cls.empty", 32'(count), 32'd0);

    // Fill with 6 offered values: only 4 taken; pop 2, push 5 and 6.
    for (int i = 0; i < 6; i++) v[i] = 32'h40000000 + 32'(i + 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_result = v[i]; in_dest = 5'(10 + i);
      cyc();
    end
    in_valid = 1'b0;
    chk("fill.count",  32'(count), 32'd4);
    chk("fill.iready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("fill.order%0d", i), out_result, v[i]);
      chk($sformatf("fill.dest%0d", i),  32'(out_dest), 32'(10 + i));
      cyc();
    end
    out_ready = 1'b0;
    chk("fill.count2", 32'(count), 32'd2);
    for (int i = 4; i < 6; i++) begin
      in_valid = 1'b1; in_result = v[i]; in_dest = 5'(10 + i);
      cyc();
    end
    in_valid = 1'b0;
    chk("fill.count4", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      chk($sformatf("wrap.order%0d", i), out_result, v[i]);
      chk($sformatf("wrap.dest%0d", i),  32'(out_dest), 32'(10 + i));
      cyc();
    end
    out_ready = 1'b0;
    chk("wrap.empty", 32'(out_valid), 32'd0);

    // Full with simultaneous pop: the push is refused.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_result = 32'hC0000000 + 32'(i); in_dest = 5'(20 + i);
      cyc();
    end
    in_result = 32'hC0000004; in_dest = 5'd24; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("fullpop.count",  32'(count), 32'd3);
    chk("fullpop.head",   out_result, 32'hC0000001);
    chk("fullpop.iready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("fullpop.order%0d", i), out_result, 32'hC0000000 + 32'(i));
      cyc();
    end
    out_ready = 1'b0;
    chk("fullpop.empty", 32'(count), 32'd0);
    chk("fullpop.hold",  out_result, 32'hC0000003);

    // Flush beats a concurrent push and pop.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_result = 32'h3F800000 + 32'(i); in_dest = 5'(i);
      cyc();
    end
    chk("flush.pre", 32'(count), 32'd2);
    flush = 1'b1; in_result = 32'h3F800009; out_ready = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush.count",  32'(count), 32'd0);
    chk("flush.ovalid", 32'(out_valid), 32'd0);
    chk("flush.iready", 32'(in_ready), 32'd1);
    chk("flush.hold",   out_result, 32'hC0000003);

    // Full queue: flush must not open in_ready combinationally.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_result = 32'h50000000 + 32'(i); in_dest = 5'(i);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flushfull.iready", 32'(in_ready), 32'd0);
    cyc();
    flush = 1'b0;
    chk("flushfull.count", 32'(count), 32'd0);
    in_valid = 1'b1; in_result = 32'h12345678; in_dest = 5'd31;
    cyc();
    in_valid = 1'b0;
    chk("postflush.result", out_result, 32'h12345678);
    chk("postflush.dest",   32'(out_dest), 32'd31);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Async reset between edges with three entries queued.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_result = 32'h60000000 + 32'(i); in_dest = 5'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("areset.pre", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("areset");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_result = 32'hBF800000; in_dest = 5'd3;
    cyc();
    in_valid = 1'b0;
    chk("firstpush.count", 32'(count), 32'd1);
    chk("firstpush.res",   out_result, 32'hBF800000);
    chk("firstpush.flags", 32'(out_flags), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
